// File: rtl/tlk2711_pkg.sv
// Shared types and constants for the TLK2711 transmit path.
package tlk2711_pkg;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_LOAD  = 3'd1,
    TX_START = 3'd2,
    TX_RUN   = 3'd3,
    TX_DONE  = 3'd4
  } tx_state_e;

  localparam int unsigned FRAME_BYTES_DEFAULT = 512;

  // 8b/10b control characters used by the framer.
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;

  function automatic int unsigned frame_log2(input int unsigned fb);
    return $clog2(fb);
  endfunction

  function automatic logic [31:0] tail_mask(input int unsigned fb);
    return 32'(fb - 1);
  endfunction

endpackage

// File: rtl/tlk2711_frame_calc.sv
// Splits a transfer length into full frames and a tail, and generates
// the per-frame DMA address (accumulated) and byte count.
module tlk2711_frame_calc
  import tlk2711_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEFAULT,
  parameter int unsigned BTT_W       = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             start_i,
  input  logic             adv_i,
  input  logic [31:0]      base_i,
  input  logic [31:0]      len_i,
  input  logic [31:0]      issued_i,
  output logic [31:0]      body_o,
  output logic [9:0]       tail_o,
  output logic [31:0]      total_o,
  output logic [31:0]      addr_o,
  output logic [BTT_W-1:0] btt_o
);

  localparam int unsigned      LOG2_FB  = frame_log2(FRAME_BYTES);
  localparam logic [31:0]      MASK     = tail_mask(FRAME_BYTES);
  localparam logic [31:0]      STEP     = 32'(FRAME_BYTES);
  localparam logic [BTT_W-1:0] FULL_BTT = BTT_W'(FRAME_BYTES);

  logic [31:0]      body_q, body_d, total_q, total_d, addr_q, addr_d, tail_full_s;
  logic [9:0]       tail_q, tail_d;
  logic [BTT_W-1:0] btt_q, btt_d;
  logic             last_s;

  assign tail_full_s = len_i & MASK;
  // issued_i is the next-state issue count, so btt lines up with the next command.
  assign last_s      = (issued_i == total_q - 32'd1) && (tail_q != 10'd0);

  always_comb begin
    body_d  = body_q;
    tail_d  = tail_q;
    total_d = total_q;
    addr_d  = addr_q;
    if (load_i) begin
      body_d  = len_i >> LOG2_FB;
      tail_d  = tail_full_s[9:0];
      total_d = (len_i >> LOG2_FB) + {31'd0, (tail_full_s != 32'd0)};
    end else begin
      body_d  = body_q;
    end
    if (start_i) begin
      addr_d = base_i;
    end else if (adv_i) begin
      addr_d = addr_q + STEP;
    end else begin
      addr_d = addr_q;
    end
    btt_d = last_s ? BTT_W'(tail_q) : FULL_BTT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      body_q  <= 32'd0;
      tail_q  <= 10'd0;
      total_q <= 32'd0;
      addr_q  <= 32'd0;
      btt_q   <= '0;
    end else begin
      body_q  <= body_d;
      tail_q  <= tail_d;
      total_q <= total_d;
      addr_q  <= addr_d;
      btt_q   <= btt_d;
    end
  end

  assign body_o  = body_q;
  assign tail_o  = tail_q;
  assign total_o = total_q;
  assign addr_o  = addr_q;
  assign btt_o   = btt_q;

endmodule

// File: rtl/tlk2711_tx_ctrl.sv
// Transfer controller ahead of the TLK2711 TX framer: splits one request into
// frames, commands the framer and datamover, and paces against frame completion.
module tlk2711_tx_ctrl
  import tlk2711_pkg::*;
#(
  parameter int unsigned FRAME_BYTES     = FRAME_BYTES_DEFAULT,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned BTT_W           = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tx_req,
  input  logic [31:0]      i_tx_base_addr,
  input  logic [31:0]      i_tx_length,
  output logic             o_tx_busy,
  output logic             o_tx_done,
  output logic             o_tx_err,
  output logic [31:0]      o_frame_cnt,
  output logic             o_dma_cmd_valid,
  input  logic             i_dma_cmd_ready,
  output logic [31:0]      o_dma_cmd_addr,
  output logic [BTT_W-1:0] o_dma_cmd_btt,
  output logic [31:0]      o_packet_body,
  output logic [9:0]       o_packet_tail,
  output logic             o_send_start,
  input  logic             i_frame_done
);

  tx_state_e   state_q, state_d;
  logic [31:0] base_q, len_q, issued_q, issued_d, completed_q, completed_d;
  logic [31:0] frame_cnt_q, frame_cnt_d, total_s;
  logic [3:0]  outstanding_q, outstanding_d;
  logic        busy_q, done_q, err_q, valid_q, send_start_q;
  logic        req_bad_s, hs_s, fd_ok_s, fd_bad_s, valid_d;

  assign req_bad_s = (i_tx_length == 32'd0) || (i_tx_base_addr[2:0] != 3'd0);
  assign hs_s      = valid_q && i_dma_cmd_ready;
  // Outside RUN nothing is outstanding, so any frame-done there is spurious.
  assign fd_ok_s   = i_frame_done && (outstanding_q != 4'd0);
  assign fd_bad_s  = i_frame_done && (outstanding_q == 4'd0);

  always_comb begin
    state_d       = state_q;
    issued_d      = issued_q;
    completed_d   = completed_q;
    outstanding_d = outstanding_q;
    frame_cnt_d   = frame_cnt_q;
    case (state_q)
      TX_IDLE: begin
        if (i_tx_req && !req_bad_s) state_d = TX_LOAD;
        else                        state_d = TX_IDLE;
      end
      TX_LOAD: begin
        state_d       = TX_START;
        issued_d      = 32'd0;
        completed_d   = 32'd0;
        outstanding_d = 4'd0;
        frame_cnt_d   = 32'd0;
      end
      TX_START: state_d = TX_RUN;
      TX_RUN: begin
        if (hs_s) issued_d = issued_q + 32'd1;
        else      issued_d = issued_q;
        if (fd_ok_s) begin
          completed_d = completed_q + 32'd1;
          frame_cnt_d = frame_cnt_q + 32'd1;
        end else begin
          completed_d = completed_q;
          frame_cnt_d = frame_cnt_q;
        end
        case ({hs_s, fd_ok_s})
          2'b10:   outstanding_d = outstanding_q + 4'd1;
          2'b01:   outstanding_d = outstanding_q - 4'd1;
          default: outstanding_d = outstanding_q;
        endcase
        if (completed_d == total_s) state_d = TX_DONE;
        else                        state_d = TX_RUN;
      end
      TX_DONE: state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end

  assign valid_d = (state_d == TX_RUN) && (issued_d < total_s) &&
                   (outstanding_d < 4'(MAX_OUTSTANDING));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= TX_IDLE;
      base_q        <= 32'd0;
      len_q         <= 32'd0;
      issued_q      <= 32'd0;
      completed_q   <= 32'd0;
      outstanding_q <= 4'd0;
      frame_cnt_q   <= 32'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      valid_q       <= 1'b0;
      send_start_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      issued_q      <= issued_d;
      completed_q   <= completed_d;
      outstanding_q <= outstanding_d;
      frame_cnt_q   <= frame_cnt_d;
      if (state_q == TX_IDLE && i_tx_req && !req_bad_s) begin
        base_q <= i_tx_base_addr;
        len_q  <= i_tx_length;
      end
      busy_q       <= (state_d == TX_LOAD) || (state_d == TX_START) || (state_d == TX_RUN);
      done_q       <= (state_d == TX_DONE);
      err_q        <= ((state_q == TX_IDLE) && i_tx_req && req_bad_s) || fd_bad_s;
      valid_q      <= valid_d;
      send_start_q <= (state_d == TX_START);
    end
  end

  tlk2711_frame_calc #(
    .FRAME_BYTES (FRAME_BYTES),
    .BTT_W       (BTT_W)
  ) u_frame_calc (
    .clk      (clk),
    .rst      (rst),
    .load_i   (state_q == TX_LOAD),
    .start_i  (state_q == TX_START),
    .adv_i    (hs_s),
    .base_i   (base_q),
    .len_i    (len_q),
    .issued_i (issued_d),
    .body_o   (o_packet_body),
    .tail_o   (o_packet_tail),
    .total_o  (total_s),
    .addr_o   (o_dma_cmd_addr),
    .btt_o    (o_dma_cmd_btt)
  );

  assign o_tx_busy       = busy_q;
  assign o_tx_done       = done_q;
  assign o_tx_err        = err_q;
  assign o_frame_cnt     = frame_cnt_q;
  assign o_dma_cmd_valid = valid_q;
  assign o_send_start    = send_start_q;

endmodule

// File: tb/tb_tlk2711_tx_ctrl.sv
// Scoreboard bench for tlk2711_tx_ctrl: stimulus pushes expected framer and DMA
// commands from a frame-splitting model; a negedge monitor pops and compares.
module tb_tlk2711_tx_ctrl;
  localparam int unsigned FB    = 512;
  localparam int unsigned MAXO  = 2;
  localparam int unsigned BTT_W = 23;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_tx_req = 1'b0;
  logic [31:0]      i_tx_base_addr = 32'd0;
  logic [31:0]      i_tx_length = 32'd0;
  logic             o_tx_busy, o_tx_done, o_tx_err, o_dma_cmd_valid, o_send_start;
  logic [31:0]      o_frame_cnt, o_dma_cmd_addr, o_packet_body;
  logic [BTT_W-1:0] o_dma_cmd_btt;
  logic [9:0]       o_packet_tail;
  logic             i_dma_cmd_ready = 1'b0;
  logic             i_frame_done = 1'b0;

  always #5 clk = ~clk;

  tlk2711_tx_ctrl #(.FRAME_BYTES(FB), .MAX_OUTSTANDING(MAXO), .BTT_W(BTT_W)) dut (
    .clk(clk), .rst(rst), .i_tx_req(i_tx_req), .i_tx_base_addr(i_tx_base_addr),
    .i_tx_length(i_tx_length), .o_tx_busy(o_tx_busy), .o_tx_done(o_tx_done),
    .o_tx_err(o_tx_err), .o_frame_cnt(o_frame_cnt), .o_dma_cmd_valid(o_dma_cmd_valid),
    .i_dma_cmd_ready(i_dma_cmd_ready), .o_dma_cmd_addr(o_dma_cmd_addr),
    .o_dma_cmd_btt(o_dma_cmd_btt), .o_packet_body(o_packet_body),
    .o_packet_tail(o_packet_tail), .o_send_start(o_send_start), .i_frame_done(i_frame_done)
  );

  typedef struct { logic [31:0] addr; logic [BTT_W-1:0] btt; } cmd_t;
  typedef struct { logic [31:0] body; logic [9:0] tail; int cyc; } start_t;

  cmd_t   cmd_q[$];
  start_t start_q[$];
  int     done_q[$];
  int     err_q[$];
  int     checks = 0, errors = 0, cyc = 0;
  int     ready_mode = 0, fd_req = 0, fd_ack = 0, pending = 0, hs_cnt = 0;
  bit     fd_en = 1'b0;
  int     mon_out = 0, mon_pre = 0, last_fd_cyc = -10, mon_f = 0;
  cmd_t   mon_c;
  start_t mon_s;
  bit     hold_pend = 1'b0;
  logic [31:0]      hold_addr;
  logic [BTT_W-1:0] hold_btt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: frame i covers bytes [i*FB, min((i+1)*FB, len)).
  task automatic model_push(input logic [31:0] base, input logic [31:0] len);
    longint unsigned body, tail, frames;
    cmd_t   c;
    start_t s;
    body   = longint'(len) / FB;
    tail   = longint'(len) % FB;
    frames = body + ((tail != 0) ? 1 : 0);
    s.body = body[31:0];
    s.tail = tail[9:0];
    s.cyc  = cyc + 2;
    start_q.push_back(s);
    for (longint unsigned i = 0; i < frames; i++) begin
      c.addr = base + 32'(i * FB);
      c.btt  = ((i == frames - 1) && (tail != 0)) ? BTT_W'(tail) : BTT_W'(FB);
      cmd_q.push_back(c);
    end
    done_q.push_back(int'(frames));
  endtask

  task automatic request(input logic [31:0] base, input logic [31:0] len, input bit ok);
    i_tx_base_addr = base;
    i_tx_length    = len;
    i_tx_req       = 1'b1;
    if (ok) model_push(base, len);
    else    err_q.push_back(cyc + 1);
    tick();
    i_tx_req = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!o_tx_done && n < limit) begin
      tick();
      n++;
    end
    chk("done_timeout", longint'(o_tx_done), 1);
    tick();
  endtask

  task automatic wait_valid(input int limit);
    int n = 0;
    while (!o_dma_cmd_valid && n < limit) begin
      tick();
      n++;
    end
    chk("valid_timeout", longint'(o_dma_cmd_valid), 1);
  endtask

  // Datamover / framer responder.
  initial begin
    bit r;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pending = 0;
        i_dma_cmd_ready = 1'b0;
        i_frame_done = 1'b0;
      end else begin
        case (ready_mode)
          0:       r = 1'b0;
          1:       r = 1'b1;
          default: r = ($urandom_range(0, 2) != 0);
        endcase
        i_dma_cmd_ready = r;
        if (fd_req != fd_ack) begin
          fd_ack++;
          i_frame_done = 1'b1;
          if (pending > 0) pending--;
        end else if (fd_en && pending > 0 && $urandom_range(0, 2) == 0) begin
          i_frame_done = 1'b1;
          pending--;
        end else begin
          i_frame_done = 1'b0;
        end
        if (o_dma_cmd_valid && i_dma_cmd_ready) pending++;
      end
    end
  end

  // Monitor: handshakes, frame-done, start, done and error pulses.
  always @(negedge clk) begin
    if (rst) begin
      mon_out   = 0;
      hold_pend = 1'b0;
    end else begin
      if (hold_pend)
        chk("cmd_hold", {o_dma_cmd_valid, o_dma_cmd_addr, o_dma_cmd_btt}, {1'b1, hold_addr, hold_btt});
      hold_pend = o_dma_cmd_valid && !i_dma_cmd_ready;
      hold_addr = o_dma_cmd_addr;
      hold_btt  = o_dma_cmd_btt;
      mon_pre = mon_out;
      if (o_dma_cmd_valid && i_dma_cmd_ready) begin
        hs_cnt++;
        chk("outstanding_bound", longint'(mon_pre < int'(MAXO)), 1);
        if (cmd_q.size() == 0) chk("cmd_unexpected", 1, 0);
        else begin
          mon_c = cmd_q.pop_front();
          chk("cmd_addr", o_dma_cmd_addr, mon_c.addr);
          chk("cmd_btt", o_dma_cmd_btt, mon_c.btt);
        end
        mon_out++;
      end
      if (i_frame_done && mon_pre > 0) begin
        mon_out--;
        last_fd_cyc = cyc;
      end
      if (o_send_start) begin
        if (start_q.size() == 0) chk("start_unexpected", 1, 0);
        else begin
          mon_s = start_q.pop_front();
          chk("packet_body", o_packet_body, mon_s.body);
          chk("packet_tail", o_packet_tail, mon_s.tail);
          chk("start_latency", cyc, mon_s.cyc);
        end
      end
      if (o_tx_done) begin
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          mon_f = done_q.pop_front();
          chk("frame_cnt", o_frame_cnt, mon_f);
        end
        chk("done_latency", cyc, last_fd_cyc + 1);
        chk("busy_at_done", longint'(o_tx_busy), 0);
      end
      if (o_tx_err) begin
        if (err_q.size() == 0) chk("err_unexpected", 1, 0);
        else chk("err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, {o_tx_busy, o_tx_done, o_tx_err, o_dma_cmd_valid, o_send_start}, 0);
    chk({tag, "_frame_cnt"}, o_frame_cnt, 0);
    chk({tag, "_addr"}, o_dma_cmd_addr, 0);
    chk({tag, "_btt"}, o_dma_cmd_btt, 0);
    chk({tag, "_body"}, o_packet_body, 0);
    chk({tag, "_tail"}, o_packet_tail, 0);
  endtask

  initial begin
    logic [31:0]      a0, base, len;
    logic [BTT_W-1:0] b0;
    int               hs0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    ready_mode = 2; fd_en = 1'b1;
    request(32'h1000_0000, 32'd1536, 1'b1); wait_done(2000);
    request(32'h1000_0000, 32'd1100, 1'b1); wait_done(2000);

    // Spurious frame-done in IDLE.
    fd_req++; err_q.push_back(cyc + 2);
    repeat (3) tick();
    chk("frame_cnt_hold", o_frame_cnt, 3);

    request(32'h2000_0000, 32'd0, 1'b0); tick();
    chk("busy_len0", longint'(o_tx_busy), 0);
    request(32'h0000_1004, 32'd1024, 1'b0); tick();
    chk("busy_misaligned", longint'(o_tx_busy), 0);

    // Ready stall and outstanding limit.
    ready_mode = 0; fd_en = 1'b0;
    request(32'h3000_0000, 32'd1536, 1'b1);
    wait_valid(20);
    a0 = o_dma_cmd_addr; b0 = o_dma_cmd_btt; hs0 = hs_cnt;
    i_tx_req = 1'b1; i_tx_length = 32'd0; tick(); i_tx_req = 1'b0;
    repeat (4) begin
      tick();
      chk("stall_hold", {o_dma_cmd_valid, o_dma_cmd_addr, o_dma_cmd_btt}, {1'b1, a0, b0});
    end
    ready_mode = 1;
    repeat (6) tick();
    chk("issue_limit_hs", hs_cnt - hs0, 2);
    chk("issue_limit_valid", longint'(o_dma_cmd_valid), 0);
    fd_req++; tick(); tick();
    chk("third_issue", {o_dma_cmd_valid, o_dma_cmd_addr}, {1'b1, 32'h3000_0400});
    ready_mode = 2; fd_en = 1'b1; wait_done(2000);

    // Command handshake and frame-done in the same cycle.
    ready_mode = 0; fd_en = 1'b0;
    request(32'h4000_0000, 32'd1536, 1'b1);
    wait_valid(20);
    ready_mode = 1; tick(); ready_mode = 0; tick();
    ready_mode = 1; fd_req++; tick(); ready_mode = 0; tick();
    chk("hs_fd_same_cycle", {o_dma_cmd_valid, o_dma_cmd_addr}, {1'b1, 32'h4000_0400});
    ready_mode = 2; fd_en = 1'b1; wait_done(2000);

    // Reset mid-transfer with a command pending.
    ready_mode = 0; fd_en = 1'b0;
    request(32'h5000_0000, 32'd4096, 1'b1);
    wait_valid(20);
    rst = 1'b1; tick();
    check_all_zero("midrst");
    cmd_q.delete(); start_q.delete(); done_q.delete();
    rst = 1'b0; tick();
    ready_mode = 2; fd_en = 1'b1;
    request(32'h5000_0000, 32'd1100, 1'b1); wait_done(2000);

    for (int k = 0; k < 20; k++) begin
      if (k % 5 == 2) begin
        request($urandom | 32'd1, 32'd100, 1'b0); tick();
      end
      len  = $urandom_range(1, 5000);
      base = $urandom & 32'hFFFF_FFF8;
      request(base, len, 1'b1);
      if (k % 4 == 0) begin
        i_tx_base_addr = $urandom; i_tx_length = $urandom_range(1, 4000);
        i_tx_req = 1'b1; tick(); i_tx_req = 1'b0;
      end
      wait_done(3000);
    end

    repeat (5) tick();
    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("start_q_empty", start_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
